// File: rtl/dbg_monitor_if.sv
// Board-side bundle of the debug monitor: run control inputs, CPU observation
// inputs, and the monitor's enable/status/display outputs.
interface dbg_monitor_if #(
   parameter int CYCLE_W = 32,
   parameter int CKSM_W  = 16,
   parameter int NUM_CH  = 8,
   parameter int DIGITS  = 4
);
   localparam int SEL_W = $clog2(NUM_CH + 1);

   logic                       halt_sw;
   logic                       step_n;
   logic                       bp_en;
   logic [CYCLE_W-1:0]         bp_cycle;
   logic [15:0]                pc;
   logic [NUM_CH*DIGITS*4-1:0] ch_data;
   logic [SEL_W-1:0]           ch_sel;
   logic                       cpu_en;
   logic                       halted;
   logic [CYCLE_W-1:0]         cycles;
   logic [CKSM_W-1:0]          cksm;
   logic [DIGITS*7-1:0]        hex;

   modport master (
      output halt_sw, step_n, bp_en, bp_cycle, pc, ch_data, ch_sel,
      input  cpu_en, halted, cycles, cksm, hex
   );

   modport slave (
      input  halt_sw, step_n, bp_en, bp_cycle, pc, ch_data, ch_sel,
      output cpu_en, halted, cycles, cksm, hex
   );
endinterface

// File: rtl/dbg_monitor.sv
// On-board debug monitor: CPU clock-enable with breakpoint/halt/single-step,
// cycle counter and hex display. Define DBG_MON_CKSM_EN to add the PC checksum.
module dbg_monitor #(
   parameter int CYCLE_W  = 32,
   parameter int CKSM_W   = 16,
   parameter int NUM_CH   = 8,
   parameter int DIGITS   = 4,
   parameter int DEBOUNCE = 4096
) (
   input  logic          cpu_clk,
   input  logic          rst,
   dbg_monitor_if.slave  bus
);
   localparam int DW    = DIGITS * 4;
   localparam int SEL_W = $clog2(NUM_CH + 1);
   localparam int CNT_W = $clog2(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_STEP} state_t;

   state_t              state_q, state_d;
   logic                step_meta_q, step_sync_q;
   logic                db_level_q, db_level_d;
   logic [CNT_W-1:0]    db_cnt_q, db_cnt_d;
   logic                step_evt_q, step_evt_d;
   logic                bp_stop_q, bp_stop_d;
   logic                bp_hit;
   logic                cpu_en;
   logic [CYCLE_W-1:0]  cycles_q, cycles_d;
   logic [DIGITS*7-1:0] hex_q, hex_d, hex_font;
   logic [DW-1:0]       ch_arr [NUM_CH];
   logic [DW-1:0]       sel_data, extra_data;
   logic                sel_valid, extra_sel;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
      endcase
   endfunction

   // Debounce: the synchronised key must disagree with the accepted level for
   // DEBOUNCE consecutive cycles; any agreement in between restarts the count.
   always_comb begin
      db_cnt_d   = '0;
      db_level_d = db_level_q;
      if (step_sync_q != db_level_q) begin
         if (db_cnt_q == CNT_LAST) begin
            db_level_d = step_sync_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
      step_evt_d = db_level_q & ~db_level_d;
   end

   assign bp_hit = bus.bp_en && (cycles_q == bus.bp_cycle);

   always_comb begin
      bp_stop_d = bp_stop_q;
      if (!bus.bp_en) begin
         bp_stop_d = 1'b0;
      end else if (state_q == ST_RUN && bp_hit) begin
         bp_stop_d = 1'b1;
      end
   end

   // cpu_en is combinational in RUN so a breakpoint or halt masks the very
   // cycle it is detected in.
   always_comb begin
      state_d = state_q;
      cpu_en  = 1'b0;
      case (state_q)
         ST_RUN: begin
            cpu_en = !bus.halt_sw && !bp_hit;
            if (bus.halt_sw || bp_hit) state_d = ST_HALT;
         end
         ST_HALT: begin
            if (step_evt_q) begin
               state_d = ST_STEP;
            end else if (!bus.halt_sw && !bp_stop_q && !bp_hit) begin
               state_d = ST_RUN;
            end
         end
         ST_STEP: begin
            cpu_en  = 1'b1;
            state_d = ST_HALT;
         end
         default: state_d = ST_HALT;
      endcase
   end

   always_comb begin
      cycles_d = cycles_q + CYCLE_W'(cpu_en);
   end

`ifdef DBG_MON_CKSM_EN
   logic [CKSM_W-1:0]    cksm_q, cksm_d;
   logic [CKSM_W+15:0]   pc_wide;
   logic [DW+CKSM_W-1:0] cksm_wide;

   assign pc_wide   = {{CKSM_W{1'b0}}, bus.pc};
   assign cksm_wide = {{DW{1'b0}}, cksm_q};

   always_comb begin
      cksm_d = cksm_q;
      if (cpu_en) cksm_d = cksm_q + pc_wide[CKSM_W-1:0];
   end

   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) cksm_q <= '0;
      else     cksm_q <= cksm_d;
   end

   assign bus.cksm   = cksm_q;
   assign extra_sel  = (bus.ch_sel == SEL_W'(NUM_CH));
   assign extra_data = cksm_wide[DW-1:0];
`else
   logic unused_pc;
   assign unused_pc  = ^bus.pc;
   assign bus.cksm   = '0;
   assign extra_sel  = 1'b0;
   assign extra_data = '0;
`endif

   genvar gi;
   for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign ch_arr[gi] = bus.ch_data[gi*DW +: DW];
   end
   for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign hex_font[gi*7 +: 7] = seg7(sel_data[gi*4 +: 4]);
   end

   always_comb begin
      sel_data  = extra_data;
      sel_valid = extra_sel;
      for (int c = 0; c < NUM_CH; c++) begin
         if (bus.ch_sel == SEL_W'(c)) begin
            sel_data  = ch_arr[c];
            sel_valid = 1'b1;
         end
      end
   end

   always_comb begin
      hex_d = sel_valid ? hex_font : '1;
   end

   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) begin
         step_meta_q <= 1'b1;
         step_sync_q <= 1'b1;
         db_level_q  <= 1'b1;
         db_cnt_q    <= '0;
         step_evt_q  <= 1'b0;
         bp_stop_q   <= 1'b0;
         state_q     <= ST_HALT;
         cycles_q    <= '0;
         hex_q       <= '1;
      end else begin
         step_meta_q <= bus.step_n;
         step_sync_q <= step_meta_q;
         db_level_q  <= db_level_d;
         db_cnt_q    <= db_cnt_d;
         step_evt_q  <= step_evt_d;
         bp_stop_q   <= bp_stop_d;
         state_q     <= state_d;
         cycles_q    <= cycles_d;
         hex_q       <= hex_d;
      end
   end

   assign bus.cpu_en = cpu_en;
   assign bus.halted = (state_q != ST_RUN);
   assign bus.cycles = cycles_q;
   assign bus.hex    = hex_q;
endmodule

// File: tb/tb_dbg_monitor.sv
// Directed bench for dbg_monitor: a cycle-level behavioural model is compared
// on every falling edge, plus literal expectations at each test milestone.
module tb_dbg_monitor;
   localparam int CYCLE_W  = 32;
   localparam int CKSM_W   = 16;
   localparam int NUM_CH   = 8;
   localparam int DIGITS   = 4;
   localparam int DEBOUNCE = 4096;
   localparam int DW       = DIGITS * 4;
   localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;

   logic cpu_clk = 1'b0;
   logic rst     = 1'b1;
   always #5 cpu_clk = ~cpu_clk;

   dbg_monitor_if #(.CYCLE_W(CYCLE_W), .CKSM_W(CKSM_W), .NUM_CH(NUM_CH), .DIGITS(DIGITS)) bus ();

   dbg_monitor #(.CYCLE_W(CYCLE_W), .CKSM_W(CKSM_W), .NUM_CH(NUM_CH), .DIGITS(DIGITS),
                 .DEBOUNCE(DEBOUNCE)) dut (
      .cpu_clk (cpu_clk),
      .rst     (rst),
      .bus     (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DIGITS*7-1:0] disp(input logic [3:0] sel,
                                                input logic [NUM_CH*DW-1:0] data,
                                                input logic [15:0] ck);
      logic [DW-1:0] v;
      logic [DIGITS*7-1:0] r;
      if (sel < NUM_CH) begin
         v = DW'(data >> (int'(sel) * DW));
`ifdef DBG_MON_CKSM_EN
      end else if (int'(sel) == NUM_CH) begin
         v = ck;
`endif
      end else begin
         return '1;
      end
      for (int d = 0; d < DIGITS; d++) r[d*7 +: 7] = FONT[v[d*4 +: 4]];
      return r;
   endfunction

   // Behavioural model state, valid for the current clock cycle.
   int              m_mode;
   logic [31:0]     m_cycles;
   logic [15:0]     m_cksm;
   bit              m_bpstop, m_level, m_evt, m_p1, m_p2;
   int              m_run;
   logic [27:0]     m_hex;

   int en_pulses  = 0;
   int en_at_100  = 0;

   always @(negedge cpu_clk) begin
      bit hit, exp_en, level_n, sync_v;
      if (rst) begin
         m_mode = M_HALT; m_cycles = 0; m_cksm = 0; m_bpstop = 0;
         m_level = 1; m_evt = 0; m_p1 = 1; m_p2 = 1; m_run = 0; m_hex = '1;
         chk("rst_cpu_en", bus.cpu_en, 0);
         chk("rst_halted", bus.halted, 1);
         chk("rst_cycles", bus.cycles, 0);
         chk("rst_hex", bus.hex, m_hex);
      end else begin
         hit = bus.bp_en && (m_cycles == bus.bp_cycle);
         if (m_mode == M_RUN)       exp_en = !bus.halt_sw && !hit;
         else if (m_mode == M_STEP) exp_en = 1;
         else                       exp_en = 0;

         chk("cpu_en", bus.cpu_en, exp_en);
         chk("halted", bus.halted, m_mode != M_RUN);
         chk("cycles", bus.cycles, m_cycles);
`ifdef DBG_MON_CKSM_EN
         chk("cksm", bus.cksm, m_cksm);
`else
         chk("cksm", bus.cksm, 0);
`endif
         chk("hex", bus.hex, m_hex);

         if (bus.cpu_en) en_pulses++;
         if (bus.cpu_en && bus.bp_en && bus.cycles == 100) en_at_100++;

         m_hex = disp(bus.ch_sel, bus.ch_data, m_cksm);
         if (exp_en) begin
            m_cycles = m_cycles + 1;
            m_cksm   = m_cksm + bus.pc;
         end
         if (m_mode == M_RUN) begin
            if (bus.halt_sw || hit) m_mode = M_HALT;
            if (bus.bp_en && hit) m_bpstop = 1;
         end else if (m_mode == M_HALT) begin
            if (m_evt) m_mode = M_STEP;
            else if (!bus.halt_sw && !m_bpstop && !hit) m_mode = M_RUN;
         end else begin
            m_mode = M_HALT;
         end
         if (!bus.bp_en) m_bpstop = 0;

         sync_v  = m_p2;
         level_n = m_level;
         if (sync_v != m_level) begin
            m_run++;
            if (m_run == DEBOUNCE) begin
               level_n = sync_v;
               m_run   = 0;
            end
         end else begin
            m_run = 0;
         end
         m_evt   = m_level && !level_n;
         m_level = level_n;
         m_p2    = m_p1;
         m_p1    = bus.step_n;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge cpu_clk);
         #1;
      end
   endtask

   initial begin
      int n_run;
      bus.halt_sw  = 1'b1;
      bus.step_n   = 1'b1;
      bus.bp_en    = 1'b0;
      bus.bp_cycle = '0;
      bus.pc       = '0;
      bus.ch_sel   = 4'd9;
      bus.ch_data  = {16'hFEDC, 16'hBA98, 16'h7654, 16'h3210,
                      16'h1A2F, 16'hC0DE, 16'h9B5E, 16'h0000};
      rst = 1'b1;
      tick(3);
      chk("reset_hex_blank", bus.hex, 28'hFFFFFFF);
      chk("reset_cpu_en", bus.cpu_en, 0);

      // Breakpoint at cycle 0 held across reset release.
      bus.bp_en = 1'b1; bus.bp_cycle = 0; bus.halt_sw = 1'b0;
      rst = 1'b0;
      tick(10);
      chk("bp0_cycles", bus.cycles, 0);
      chk("bp0_halted", bus.halted, 1);

      // Checksum and its display channel.
      rst = 1'b1; tick(2);
      bus.pc = 16'h8000; bus.bp_cycle = 3; bus.ch_sel = 4'd8;
      rst = 1'b0;
      tick(10);
      chk("ck_cycles", bus.cycles, 3);
`ifdef DBG_MON_CKSM_EN
      chk("ck_value", bus.cksm, 16'h8000);
      chk("ck_display", bus.hex, {7'h00, 7'h40, 7'h40, 7'h40});
`else
      chk("ck_value", bus.cksm, 0);
      chk("ck_display", bus.hex, 28'hFFFFFFF);
`endif

      // Breakpoint at 100 with changing pc.
      rst = 1'b1; tick(2);
      bus.bp_cycle = 100;
      en_pulses = 0; en_at_100 = 0;
      rst = 1'b0;
      for (int i = 0; i < 150; i++) begin
         bus.pc = 16'($urandom);
         tick(1);
      end
      chk("bp_en_pulses", en_pulses, 100);
      chk("bp_cycles", bus.cycles, 100);
      chk("bp_halted", bus.halted, 1);
      chk("bp_no_overshoot", en_at_100, 0);

      // Single step past the breakpoint.
      en_pulses = 0;
      bus.step_n = 1'b0;
      tick(DEBOUNCE + 3);
      bus.step_n = 1'b1;
      tick(10);
      chk("step_pulses", en_pulses, 1);
      chk("step_cycles", bus.cycles, 101);
      chk("step_halted", bus.halted, 1);
      tick(DEBOUNCE + 10);
      chk("step_stays_halted", en_pulses, 1);
      bus.bp_en = 1'b0;
      tick(2);
      chk("resume_after_bp_clear", bus.cpu_en, 1);

      // Halt switch at cycles==50; step key ignored while running.
      rst = 1'b1; tick(2);
      bus.halt_sw = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 200 && bus.cycles != 50; i++) tick(1);
      bus.halt_sw = 1'b1;
      #1;
      chk("halt_same_cycle", bus.cpu_en, 0);
      tick(5);
      chk("halt_cycles", bus.cycles, 50);
      bus.halt_sw = 1'b0;
      bus.step_n  = 1'b0;
      n_run = DEBOUNCE + 20;
      tick(n_run);
      chk("run_ignores_step", bus.cycles, 50 + n_run - 1);
      chk("run_not_halted", bus.halted, 0);
      bus.halt_sw = 1'b1;
      tick(3);
      bus.step_n = 1'b1;
      tick(DEBOUNCE + 10);
      chk("halt_hold_cycles", bus.cycles, 50 + n_run - 1);

      // Bouncing key while halted, then one clean press.
      en_pulses = 0;
      for (int i = 0; i < 10; i++) begin
         bus.step_n = ~bus.step_n;
         tick(100);
      end
      tick(DEBOUNCE + 10);
      chk("bounce_rejected", en_pulses, 0);
      bus.step_n = 1'b0;
      tick(DEBOUNCE + 10);
      bus.step_n = 1'b1;
      tick(DEBOUNCE + 10);
      chk("step_under_halt_sw", en_pulses, 1);
      chk("step_under_halt_cycles", bus.cycles, 50 + n_run);

      // Display channels.
      bus.ch_sel = 4'd3; tick(1);
      chk("disp_ch3", bus.hex, {7'h79, 7'h08, 7'h24, 7'h0E});
      bus.ch_sel = 4'd9; tick(1);
      chk("disp_ch9_blank", bus.hex, 28'hFFFFFFF);
      bus.ch_sel = 4'd0; tick(1);
      chk("disp_ch0", bus.hex, {7'h40, 7'h40, 7'h40, 7'h40});
      bus.ch_sel = 4'd7; tick(1);
      chk("disp_ch7", bus.hex, {7'h0E, 7'h06, 7'h21, 7'h46});

      // Asynchronous reset while running.
      bus.halt_sw = 1'b0;
      tick(5);
      rst = 1'b1;
      #1;
      chk("async_rst_cpu_en", bus.cpu_en, 0);
      chk("async_rst_cycles", bus.cycles, 0);
      tick(2);
      rst = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end
endmodule
